// File: rtl/uart_pkg.sv
// Shared types and framing constants for the UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..period and flags the last cycle of each bit.
module uart_bit_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] period,
    output logic             bit_end
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bit_end = (r_cnt == period);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop; all outputs registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count,
    input  logic [7:0]       data_byte,
    input  logic             tx_dv,
    output logic             serial_out,
    output logic             tx_active,
    output logic             tx_done
);

    uart_state_e            r_state,   w_state;
    logic [CNT_W-1:0]       r_count,   w_count;
    logic [DATA_BITS-1:0]   r_shift,   w_shift;
    logic [2:0]             r_bit_idx, w_bit_idx;
    logic                   r_parity,  w_parity;
    logic                   r_serial,  w_serial;
    logic                   r_active,  w_active;
    logic                   r_done,    w_done;
    logic                   w_bit_end;
    logic                   w_clear;

    // The counter restarts on acceptance (held clear in IDLE) and at every bit boundary.
    assign w_clear = (r_state == IDLE) || w_bit_end;

    uart_bit_timer #(.CNT_W(CNT_W)) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .period  (r_count),
        .bit_end (w_bit_end)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state   = r_state;
        w_count   = r_count;
        w_shift   = r_shift;
        w_bit_idx = r_bit_idx;
        w_parity  = r_parity;
        w_serial  = r_serial;
        w_active  = r_active;
        w_done    = 1'b0;

        case (r_state)
            IDLE: begin
                w_serial = STOP_BIT;
                w_active = 1'b0;
                if (tx_dv) begin
                    w_state   = START;
                    w_count   = count;
                    w_shift   = data_byte;
                    w_parity  = (^data_byte) ^ PARITY_ODD;
                    w_bit_idx = '0;
                    w_serial  = START_BIT;
                    w_active  = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state   = DATA;
                    w_bit_idx = '0;
                    w_serial  = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                        w_state  = PARITY;
                        w_serial = r_parity;
                    end else begin
                        w_bit_idx = r_bit_idx + 3'd1;
                        w_shift   = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_serial  = r_shift[1];
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state  = STOP;
                    w_serial = STOP_BIT;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state  = IDLE;
                    w_serial = STOP_BIT;
                    w_active = 1'b0;
                    w_done   = 1'b1;
                end
            end
            default: begin
                w_state  = IDLE;
                w_serial = STOP_BIT;
                w_active = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
            r_serial  <= STOP_BIT;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_count   <= w_count;
            r_shift   <= w_shift;
            r_bit_idx <= w_bit_idx;
            r_parity  <= w_parity;
            r_serial  <= w_serial;
            r_active  <= w_active;
            r_done    <= w_done;
        end
    end

    assign serial_out = r_serial;
    assign tx_active  = r_active;
    assign tx_done    = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: an even-parity and an odd-parity instance share stimulus.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] count;
    logic [7:0] data_byte;
    logic       tx_dv;
    logic       ser_e, act_e, done_e;
    logic       ser_o, act_o, done_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx #(.PARITY_ODD(1'b0), .CNT_W(8)) dut_even (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .data_byte  (data_byte),
        .tx_dv      (tx_dv),
        .serial_out (ser_e),
        .tx_active  (act_e),
        .tx_done    (done_e)
    );

    uart_tx #(.PARITY_ODD(1'b1), .CNT_W(8)) dut_odd (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .data_byte  (data_byte),
        .tx_dv      (tx_dv),
        .serial_out (ser_o),
        .tx_active  (act_o),
        .tx_done    (done_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered on the first START cycle; returns on the cycle where tx_done should be high.
    // Optionally changes data_byte/count at the start of bit chg_bit.
    task automatic check_frame(input string tag, input logic [7:0] d, input logic par,
                               input int cnt, input bit sel, input int chg_bit,
                               input logic [7:0] nd, input logic [7:0] nc);
        logic [10:0] bits;
        logic        s, a, dn;
        int          bad;
        bits = {1'b1, par, d, 1'b0};
        bad  = 0;
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c <= cnt; c++) begin
                s  = sel ? ser_o  : ser_e;
                a  = sel ? act_o  : act_e;
                dn = sel ? done_o : done_e;
                if (c == 0)
                    check($sformatf("%s_bit%0d", tag, b), {31'd0, s}, {31'd0, bits[b]});
                else if (s !== bits[b])
                    bad++;
                if (a !== 1'b1 || dn !== 1'b0)
                    bad++;
                if (b == chg_bit && c == 0) begin
                    data_byte = nd;
                    count     = nc;
                end
                tick();
            end
        end
        check({tag, "_hold"}, bad, 0);
        check({tag, "_done"},   {31'd0, sel ? done_o : done_e}, 32'd1);
        check({tag, "_act_end"}, {31'd0, sel ? act_o : act_e},  32'd0);
        check({tag, "_line_hi"}, {31'd0, sel ? ser_o : ser_e},  32'd1);
    endtask

    initial begin
        rst       = 1'b0;
        tx_dv     = 1'b1;
        count     = 8'd127;
        data_byte = 8'hAA;

        // Reset held with a pending request: line stays idle.
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_ser",  {31'd0, ser_e},  32'd1);
            check("rst_act",  {31'd0, act_e},  32'd0);
            check("rst_done", {31'd0, done_e}, 32'd0);
        end
        tx_dv = 1'b0;
        rst   = 1'b1;
        tick();
        tick();
        check("post_rst_ser", {31'd0, ser_e}, 32'd1);
        check("post_rst_act", {31'd0, act_e}, 32'd0);

        // Single frame 0xAA, count 127, even parity 0.
        tx_dv = 1'b1;
        tick();
        tx_dv = 1'b0;
        check_frame("aa127", 8'hAA, 1'b0, 127, 1'b0, -1, 8'h00, 8'h00);
        tick();
        check("aa127_done_1cyc", {31'd0, done_e}, 32'd0);
        check("aa127_idle_ser",  {31'd0, ser_e},  32'd1);

        // 0x07, count 3: odd DUT parity 0, even DUT parity 1.
        count     = 8'd3;
        data_byte = 8'h07;
        tx_dv     = 1'b1;
        tick();
        tx_dv = 1'b0;
        check_frame("odd07", 8'h07, 1'b0, 3, 1'b1, -1, 8'h00, 8'h00);
        tick();
        tx_dv = 1'b1;
        tick();
        tx_dv = 1'b0;
        check_frame("even07", 8'h07, 1'b1, 3, 1'b0, -1, 8'h00, 8'h00);
        tick();

        // Held request: back-to-back frames with a single idle-high cycle.
        count     = 8'd127;
        data_byte = 8'hAA;
        tx_dv     = 1'b1;
        tick();
        check_frame("b2b_0", 8'hAA, 1'b0, 127, 1'b0, -1, 8'h00, 8'h00);
        tick();
        tx_dv = 1'b0;
        check_frame("b2b_1", 8'hAA, 1'b0, 127, 1'b0, -1, 8'h00, 8'h00);
        tick();
        check("b2b_stop_ser", {31'd0, ser_e},  32'd1);
        check("b2b_stop_act", {31'd0, act_e},  32'd0);
        check("b2b_stop_done", {31'd0, done_e}, 32'd0);

        // Inputs changed during DATA are ignored until the next frame.
        tx_dv = 1'b1;
        tick();
        tx_dv = 1'b0;
        check_frame("chg_cur", 8'hAA, 1'b0, 127, 1'b0, 3, 8'h55, 8'd10);
        tick();
        tx_dv = 1'b1;
        tick();
        tx_dv = 1'b0;
        check_frame("chg_next", 8'h55, 1'b0, 10, 1'b0, -1, 8'h00, 8'h00);
        tick();

        // Minimum period: one cycle per bit.
        count     = 8'd0;
        data_byte = 8'hFF;
        tx_dv     = 1'b1;
        tick();
        tx_dv = 1'b0;
        check_frame("ff0", 8'hFF, 1'b0, 0, 1'b0, -1, 8'h00, 8'h00);
        tick();

        // Reset during PARITY: 4 start cycles + 32 data cycles, then parity.
        count     = 8'd3;
        data_byte = 8'hAA;
        tx_dv     = 1'b1;
        tick();
        tx_dv = 1'b0;
        for (int i = 0; i < 37; i++) tick();
        check("par_before_rst_ser", {31'd0, ser_e}, 32'd0);
        check("par_before_rst_act", {31'd0, act_e}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_ser", {31'd0, ser_e},  32'd1);
        check("rst_mid_act", {31'd0, act_e},  32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_mid_nodone", {31'd0, done_e}, 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("rst_mid_quiet", {29'd0, ser_e, act_e, done_e}, 32'd4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
